// File: rtl/mdu_if.sv
// MDU operand/control bus and HI/LO result bus.
// master drives dh/dl/op/stop/restore; slave returns busy/invalid/hi/lo.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] dh;
    logic [WIDTH-1:0] dl;
    logic [3:0]       op;
    logic             stop;
    logic             restore;
    logic             busy;
    logic             invalid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output dh, dl, op, stop, restore,
        input  busy, invalid, hi, lo
    );

    modport slave (
        input  dh, dl, op, stop, restore,
        output busy, invalid, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a backup copy.
// Ports: clk, rst (sync, active-high), bus (mdu_if.slave).
module mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic  clk,
    input logic  rst,
    mdu_if.slave bus
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] bhi_q, bhi_d, blo_q, blo_d;

    logic             accept;
    logic             sgn_mul, sgn_div, a_neg, b_neg;
    logic [2*WIDTH-1:0] ax, bx, prod, hilo, res;
    logic [WIDTH-1:0] a_mag, b_mag, uq, ur, quo, rem;

    assign bus.busy    = (state_q == RUN);
    assign bus.invalid = (bus.op >= 4'd11);
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

    assign accept = (state_q == IDLE) && !bus.stop && !bus.restore &&
                    (bus.op >= 4'd1) && (bus.op <= 4'd10);

    // Sign-extending to 2*WIDTH makes the low half of the unsigned
    // product equal to the signed product.
    always_comb begin
        sgn_mul = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        ax      = {{WIDTH{sgn_mul & a_q[WIDTH-1]}}, a_q};
        bx      = {{WIDTH{sgn_mul & b_q[WIDTH-1]}}, b_q};
        prod    = ax * bx;
        hilo    = {hi_q, lo_q};
    end

    // Signed divide via magnitudes. MIN/-1 falls out naturally:
    // |MIN| = MIN, quotient MIN negated is MIN again, remainder 0.
    always_comb begin
        sgn_div = (op_q == OP_DIV);
        a_neg   = sgn_div & a_q[WIDTH-1];
        b_neg   = sgn_div & b_q[WIDTH-1];
        a_mag   = a_neg ? -a_q : a_q;
        b_mag   = b_neg ? -b_q : b_q;
        uq      = '0;
        ur      = '0;
        if (b_mag != '0) begin
            uq = a_mag / b_mag;
            ur = a_mag % b_mag;
        end
        quo = (a_neg ^ b_neg) ? -uq : uq;
        rem = a_neg ? -ur : ur;
        if (b_q == '0) begin
            quo = '1;
            rem = a_q;
        end
    end

    // HI/LO are frozen during RUN, so current HI/LO equal their value at accept.
    always_comb begin
        res = {rem, quo};
        case (op_q)
            OP_MULT, OP_MULTU: res = prod;
            OP_MADD, OP_MADDU: res = hilo + prod;
            OP_MSUB, OP_MSUBU: res = hilo - prod;
            default:           res = {rem, quo};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        bhi_d   = bhi_q;
        blo_d   = blo_q;
        if (bus.restore) begin
            state_d = IDLE;
            cnt_d   = '0;
            hi_d    = bhi_q;
            lo_d    = blo_q;
        end else if (state_q == RUN) begin
            if (cnt_q == CW'(1)) begin
                state_d      = IDLE;
                cnt_d        = '0;
                {hi_d, lo_d} = res;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else if (accept) begin
            bhi_d = hi_q;
            blo_d = lo_q;
            case (bus.op)
                OP_MTHI: hi_d = bus.dh;
                OP_MTLO: lo_d = bus.dh;
                default: begin
                    state_d = RUN;
                    op_d    = bus.op;
                    a_d     = bus.dh;
                    b_d     = bus.dl;
                    cnt_d   = (bus.op == OP_DIV || bus.op == OP_DIVU) ?
                              CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            bhi_q   <= '0;
            blo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            bhi_q   <= bhi_d;
            blo_q   <= blo_d;
        end
    end
endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: directed cases plus random ops against
// an arithmetic reference model; a negedge monitor checks busy/hi/lo.
module tb_mdu;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mdu_if #(.WIDTH(32)) bus ();

    mdu #(
        .WIDTH(32),
        .MUL_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] m_hi, m_lo, b_hi, b_lo;
    logic [63:0] m_pend;
    int          m_rem;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.busy !== e.busy || bus.hi !== e.hi || bus.lo !== e.lo) begin
                failures++;
                $display("FAIL scoreboard @%0t: got busy=%b hi=%h lo=%h expected busy=%b hi=%h lo=%h",
                         $time, bus.busy, bus.hi, bus.lo, e.busy, e.hi, e.lo);
            end
        end
    end

    function automatic logic [63:0] model_op(input logic [3:0] o,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] h,
                                             input logic [31:0] l);
        int          ia, ib;
        longint      sa, sb;
        logic [63:0] p, acc;
        logic [31:0] q, r;
        ia  = a;
        ib  = b;
        acc = {h, l};
        if (o == 4'd1 || o == 4'd7 || o == 4'd9) begin
            sa = ia;
            sb = ib;
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        p = sa * sb;
        case (o)
            4'd1, 4'd2: return p;
            4'd7, 4'd8: return acc + p;
            4'd9, 4'd10: return acc - p;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 4'd3) begin
                    if (a == 32'h8000_0000 && ib == -1) return {32'd0, a};
                    q = ia / ib;
                    r = ia % ib;
                end else begin
                    q = a / b;
                    r = a % b;
                end
                return {r, q};
            end
        endcase
    endfunction

    task automatic step(input logic r, input logic rs, input logic st,
                        input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b);
        exp_t e;
        rst         = r;
        bus.restore = rs;
        bus.stop    = st;
        bus.op      = o;
        bus.dh      = a;
        bus.dl      = b;
        #1;
        chk("invalid", 32'(bus.invalid), 32'(o >= 4'd11));
        if (r) begin
            m_hi = 0; m_lo = 0; b_hi = 0; b_lo = 0; m_rem = 0;
        end else if (rs) begin
            m_hi = b_hi; m_lo = b_lo; m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) {m_hi, m_lo} = m_pend;
        end else if (!st && o >= 4'd1 && o <= 4'd10) begin
            b_hi = m_hi;
            b_lo = m_lo;
            if (o == 4'd5) m_hi = a;
            else if (o == 4'd6) m_lo = a;
            else begin
                m_pend = model_op(o, a, b, m_hi, m_lo);
                m_rem  = (o == 4'd3 || o == 4'd4) ? 10 : 5;
            end
        end
        e.busy = (m_rem > 0);
        e.hi   = m_hi;
        e.lo   = m_lo;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        m_hi = 0; m_lo = 0; b_hi = 0; b_lo = 0; m_rem = 0; m_pend = 0;
        step(1, 0, 0, 4'd0, 32'd0, 32'd0);
        step(1, 0, 0, 4'd0, 32'd0, 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);

        step(0, 0, 0, 4'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_busy_start", 32'(bus.busy), 32'd1);
        idle(4);
        chk("mult_busy_last", 32'(bus.busy), 32'd1);
        idle(1);
        chk("mult_busy_end", 32'(bus.busy), 32'd0);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
        step(0, 0, 0, 4'd2, 32'hFFFF_FFFE, 32'd3);
        idle(5);
        chk("multu_hi", bus.hi, 32'h0000_0002);
        chk("multu_lo", bus.lo, 32'hFFFF_FFFA);

        step(0, 0, 0, 4'd4, 32'd7, 32'd0);
        idle(9);
        chk("divu0_busy_last", 32'(bus.busy), 32'd1);
        idle(1);
        chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
        chk("divu0_hi", bus.hi, 32'd7);
        step(0, 0, 0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(10);
        chk("div_ovf_lo", bus.lo, 32'h8000_0000);
        chk("div_ovf_hi", bus.hi, 32'd0);
        step(0, 0, 0, 4'd3, 32'hFFFF_FFF9, 32'd2);
        idle(10);
        chk("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", bus.hi, 32'hFFFF_FFFF);

        step(0, 0, 0, 4'd5, 32'd1, 32'd0);
        step(0, 0, 0, 4'd6, 32'd2, 32'd0);
        step(0, 0, 0, 4'd7, 32'd3, 32'd4);
        idle(5);
        chk("madd_hi", bus.hi, 32'd1);
        chk("madd_lo", bus.lo, 32'd14);
        step(0, 0, 0, 4'd5, 32'd1, 32'd0);
        step(0, 0, 0, 4'd6, 32'd2, 32'd0);
        step(0, 0, 0, 4'd7, 32'd3, 32'd4);
        idle(1);
        step(0, 1, 0, 4'd0, 32'd0, 32'd0);
        chk("restore_busy", 32'(bus.busy), 32'd0);
        idle(6);
        chk("restore_hi", bus.hi, 32'd1);
        chk("restore_lo", bus.lo, 32'd2);

        step(0, 0, 1, 4'd1, 32'd9, 32'd9);
        chk("stop_busy", 32'(bus.busy), 32'd0);
        chk("stop_lo", bus.lo, 32'd2);
        step(0, 0, 0, 4'd12, 32'd9, 32'd9);
        chk("illegal_busy", 32'(bus.busy), 32'd0);
        chk("illegal_hi", bus.hi, 32'd1);
        step(0, 0, 0, 4'd2, 32'd6, 32'd7);
        step(0, 0, 0, 4'd2, 32'd100, 32'd100);
        idle(10);
        chk("run_ignore_lo", bus.lo, 32'd42);
        chk("run_ignore_hi", bus.hi, 32'd0);

        step(0, 0, 0, 4'd2, 32'd5, 32'd5);
        idle(5);
        step(0, 0, 0, 4'd5, 32'hABCD_0123, 32'd0);
        chk("b2b_hi", bus.hi, 32'hABCD_0123);
        chk("b2b_lo", bus.lo, 32'd25);

        step(0, 0, 0, 4'd6, 32'h1234_5678, 32'd0);
        step(0, 0, 0, 4'd4, 32'd50, 32'd7);
        idle(3);
        step(1, 0, 0, 4'd0, 32'd0, 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_hi", bus.hi, 32'd0);
        chk("rst_mid_lo", bus.lo, 32'd0);
        idle(12);
        chk("rst_mid_nowb", bus.lo, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic r, rs, st;
            r  = ($urandom_range(0, 199) == 0);
            rs = ($urandom_range(0, 15) == 0);
            st = ($urandom_range(0, 7) == 0);
            step(r, rs, st, 4'($urandom_range(0, 15)), rnd_val(), rnd_val());
        end
        idle(12);
        @(negedge clk);
        #1;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width in bits.
REQ-002 Parameter MUL_CYCLES, default 5, busy duration of multiply-class ops; legal range >= 1.
REQ-003 Parameter DIV_CYCLES, default 10, busy duration of divide-class ops; legal range >= 1.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 dh  input  WIDTH  first operand (rs); also the data source for mthi/mtlo.
REQ-007 dl  input  WIDTH  second operand (rt).
REQ-008 op  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, 11-15 illegal.
REQ-009 stop  input  1  suppresses acceptance of the op presented this cycle.
REQ-010 restore  input  1  aborts any in-flight op and reverts HI/LO to the backup copy.
REQ-011 busy  output  1  high while a multi-cycle op is in flight.
REQ-012 invalid  output  1  combinational; high when op is 11-15.
REQ-013 hi, lo  output  WIDTH each  current HI and LO register contents.

Function
REQ-014 States: IDLE, RUN; a cycle counter tracks the remaining busy cycles.
REQ-015 Acceptance occurs at an edge where state=IDLE, stop=0, restore=0, rst=0, and op is 1-10; the edge is named A.
REQ-016 At every acceptance, HI/LO are copied into the backup registers before the op takes effect.
REQ-017 mthi sets hi<=dh, and mtlo sets lo<=dh, at edge A; busy stays 0.
REQ-018 For ops 1-4 and 7-10, dh, dl and op are latched at A, the state goes to RUN, and busy=1 for exactly N cycles after A, where N=MUL_CYCLES for ops 1,2,7-10 and N=DIV_CYCLES for ops 3,4.
REQ-019 The result is written to HI/LO at edge A+N; at that same edge busy falls and the state returns to IDLE.
REQ-020 A new op may be accepted in the first cycle that busy=0.
REQ-021 mult/multu: {hi,lo} <= 2*WIDTH-bit signed/unsigned product.
REQ-022 madd/maddu: {hi,lo} <= {hi,lo}@A + product; msub/msubu: {hi,lo} <= {hi,lo}@A - product; arithmetic wraps modulo 2^(2*WIDTH).
REQ-023 div/divu: lo <= quotient, hi <= remainder; the signed quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-024 Divisor zero: lo <= all ones, hi <= dividend, for both div and divu.
REQ-025 Signed overflow (dividend = minimum negative, divisor = -1): lo <= dividend, hi <= 0.
REQ-026 Any op presented while state=RUN is ignored; sequencing is the stall logic's responsibility.
REQ-027 When stop=1, the op presented that cycle has no effect.
REQ-028 Illegal ops (11-15) assert invalid and change no state.
REQ-029 restore=1 at an edge forces: state IDLE, counter 0, hi/lo <= backup; busy=0 from the next cycle.
REQ-030 restore has priority over acceptance and over a completing write-back in the same cycle.
REQ-031 restore while IDLE also reverts HI/LO to the backup, undoing the last accepted op, including mthi/mtlo.
REQ-032 hi, lo and busy are registered outputs, with no combinational path from the inputs.

Reset
REQ-033 At an edge where rst=1: hi=0, lo=0, backup=0, busy=0, state IDLE, counter 0, regardless of state; rst overrides restore and op.
REQ-034 Reset during RUN discards the in-flight op, and no write-back occurs afterwards.

Verification (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10)
REQ-035 Mult: mult dh=0xFFFFFFFE, dl=3 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-036 Divide: divu 7/0 -> busy for 10 cycles, then lo=0xFFFFFFFF, hi=7; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; div 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 Accumulate and restore: mthi 1, mtlo 2, then madd 3*4 -> hi=1, lo=14; repeat from hi=1, lo=2 with restore asserted in busy cycle 2 -> busy=0 next cycle, hi=1, lo=2, with no later write-back.
REQ-038 Suppression: mult with stop=1 -> busy stays 0 and hi/lo unchanged; op=12 -> invalid=1 and no state change; mult presented during RUN -> ignored, and only the first result lands.
REQ-039 Back-to-back: mult completes and mthi is issued in the first busy=0 cycle -> mthi accepted, hi=dh, lo holds the mult result.
REQ-040 Reset mid-op: rst asserted in div busy cycle 4 -> the next cycle shows busy=0, hi=0, lo=0, and no write-back follows.
